updown_count_driver: RTL and testbench

- Synchronous initiator for the presettable up/down counter interface: master reset, parallel load, count-up clock, count-down clock and the terminal-count returns.
- Converts one-clock command transactions into legal pulse waveforms on MR, PL_bar, CPU and CPD.
- Observes TCU_bar/TCD_bar to report carry and borrow.
- Sits between CPU-side control logic and one counter stage, or a cascaded chain of stages.

---
 rtl/updown_count_driver_pkg.sv | 25 ++
 rtl/updown_count_driver_strobe_timer.sv | 33 +++
 rtl/updown_count_driver.sv | 155 +++++++++++++++
 tb/tb_updown_count_driver.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/updown_count_driver_pkg.sv
// ---------------------------------------------------------------------------
// updown_count_driver_pkg: op-codes and FSM encoding for the counter driver.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package updown_count_driver_pkg;

  localparam logic [1:0] OP_UP    = 2'b00;
  localparam logic [1:0] OP_DOWN  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    ST_RST_HOLD  = 3'd0,
    ST_IDLE      = 3'd1,
    ST_SETUP     = 3'd2,
    ST_STROBE_LO = 3'd3,
    ST_STROBE_HI = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/updown_count_driver_strobe_timer.sv
// ---------------------------------------------------------------------------
// strobe_timer: loadable down-counter; o_tick marks the last cycle of a phase.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module strobe_timer #(
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  output logic          o_tick
);

  logic [TW-1:0] r_cnt;

  assign o_tick = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (!o_tick) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/updown_count_driver.sv
// ---------------------------------------------------------------------------
// updown_count_driver: turns one-clock commands into MR/PL_bar/CPU/CPD pulses.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module updown_count_driver
  import updown_count_driver_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int COUNT_WIDTH = 8,
  parameter int PULSE_LOW   = 2,
  parameter int PULSE_HIGH  = 2
) (
  input  logic                   CLK,
  input  logic                   RST_bar,
  input  logic                   CMD_VALID,
  output logic                   CMD_READY,
  input  logic [1:0]             CMD_OP,
  input  logic [COUNT_WIDTH-1:0] CMD_COUNT,
  input  logic [WIDTH-1:0]       CMD_DATA,
  output logic                   DONE,
  output logic                   CARRY,
  output logic                   BORROW,
  output logic                   MR,
  output logic                   PL_bar,
  output logic                   CPU,
  output logic                   CPD,
  output logic [WIDTH-1:0]       D,
  input  logic                   TCU_bar,
  input  logic                   TCD_bar
);

  localparam int TW = $clog2(((PULSE_LOW > PULSE_HIGH) ? PULSE_LOW : PULSE_HIGH) + 1);
  localparam logic [TW-1:0] c_lo_reload = TW'(PULSE_LOW - 1);
  localparam logic [TW-1:0] c_hi_reload = TW'(PULSE_HIGH - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [1:0]             r_op;
  logic [1:0]             w_op;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic                   w_accept;
  logic                   w_step_op;
  logic                   w_tick;
  logic                   w_timer_load;
  logic [TW-1:0]          w_timer_val;

  assign w_accept  = (r_state == ST_IDLE) && CMD_VALID && CMD_READY;
  assign w_op      = w_accept ? CMD_OP : r_op;
  assign w_step_op = (r_op == OP_UP) || (r_op == OP_DOWN);

  strobe_timer #(
    .TW (TW)
  ) u_timer (
    .clk        (CLK),
    .rst_n      (RST_bar),
    .i_load     (w_timer_load),
    .i_load_val (w_timer_val),
    .o_tick     (w_tick)
  );

  always_comb begin
    w_next       = r_state;
    w_timer_load = 1'b0;
    w_timer_val  = c_lo_reload;
    case (r_state)
      ST_RST_HOLD: w_next = ST_IDLE;
      ST_IDLE: begin
        if (w_accept) begin
          if (CMD_OP == OP_LOAD) begin
            w_next = ST_SETUP;
          end else if ((CMD_OP != OP_CLEAR) && (CMD_COUNT == '0)) begin
            w_next = ST_FINISH;
          end else begin
            w_next       = ST_STROBE_LO;
            w_timer_load = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        w_next       = ST_STROBE_LO;
        w_timer_load = 1'b1;
      end
      ST_STROBE_LO: begin
        if (w_tick) begin
          w_next       = ST_STROBE_HI;
          w_timer_load = 1'b1;
          w_timer_val  = c_hi_reload;
        end
      end
      ST_STROBE_HI: begin
        if (w_tick) begin
          // r_remaining was already decremented on entry to this phase
          if (w_step_op && (r_remaining != '0)) begin
            w_next       = ST_STROBE_LO;
            w_timer_load = 1'b1;
          end else begin
            w_next = ST_FINISH;
          end
        end
      end
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_RST_HOLD;
    endcase
  end

  // Strobes are registered from the next state so they line up with the phase.
  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      r_state     <= ST_RST_HOLD;
      r_op        <= OP_UP;
      r_remaining <= '0;
      MR          <= 1'b1;
      PL_bar      <= 1'b1;
      CPU         <= 1'b1;
      CPD         <= 1'b1;
      D           <= '0;
      CMD_READY   <= 1'b0;
      DONE        <= 1'b0;
      CARRY       <= 1'b0;
      BORROW      <= 1'b0;
    end else begin
      r_state   <= w_next;
      MR        <= (w_next == ST_STROBE_LO) && (w_op == OP_CLEAR);
      PL_bar    <= !((w_next == ST_STROBE_LO) && (w_op == OP_LOAD));
      CPU       <= !((w_next == ST_STROBE_LO) && (w_op == OP_UP));
      CPD       <= !((w_next == ST_STROBE_LO) && (w_op == OP_DOWN));
      CMD_READY <= (w_next == ST_IDLE);
      DONE      <= (w_next == ST_FINISH);
      if (w_accept) begin
        r_op        <= CMD_OP;
        r_remaining <= CMD_COUNT;
        CARRY       <= 1'b0;
        BORROW      <= 1'b0;
        if (CMD_OP == OP_LOAD) begin
          D <= CMD_DATA;
        end
      end else if ((r_state == ST_STROBE_LO) && w_step_op) begin
        if (!TCU_bar) begin
          CARRY <= 1'b1;
        end
        if (!TCD_bar) begin
          BORROW <= 1'b1;
        end
        if (w_next == ST_STROBE_HI) begin
          r_remaining <= r_remaining - 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_updown_count_driver.sv
// ---------------------------------------------------------------------------
// tb_updown_count_driver: driver paired with a behavioural 74193 counter model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_updown_count_driver;
  import updown_count_driver_pkg::*;

  logic       clk = 1'b0;
  logic       RST_bar = 1'b0;
  logic       CMD_VALID = 1'b0;
  logic [1:0] CMD_OP = 2'b00;
  logic [7:0] CMD_COUNT = 8'd0;
  logic [3:0] CMD_DATA = 4'd0;
  wire        CMD_READY, DONE, CARRY, BORROW, MR, PL_bar, CPU, CPD;
  wire  [3:0] D;
  wire        TCU_bar, TCD_bar;

  updown_count_driver #(
    .WIDTH(4), .COUNT_WIDTH(8), .PULSE_LOW(2), .PULSE_HIGH(2)
  ) dut (
    .CLK(clk), .RST_bar(RST_bar), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_COUNT(CMD_COUNT), .CMD_DATA(CMD_DATA), .DONE(DONE),
    .CARRY(CARRY), .BORROW(BORROW), .MR(MR), .PL_bar(PL_bar), .CPU(CPU),
    .CPD(CPD), .D(D), .TCU_bar(TCU_bar), .TCD_bar(TCD_bar)
  );

  always #5 clk = ~clk;

  // 74193-style counter: async MR and PL_bar, counts on clock rising edges
  logic [3:0] Q = 4'd0;
  logic       cpu_q = 1'b1;
  logic       cpd_q = 1'b1;
  always @(CPU or CPD or MR or PL_bar or D) begin
    if (MR === 1'b1) Q = 4'd0;
    else if (PL_bar === 1'b0) Q = D;
    else if (CPU === 1'b1 && cpu_q === 1'b0 && CPD === 1'b1) Q = Q + 4'd1;
    else if (CPD === 1'b1 && cpd_q === 1'b0 && CPU === 1'b1) Q = Q - 4'd1;
    cpu_q = CPU;
    cpd_q = CPD;
  end
  assign TCU_bar = !((Q == 4'hF) && (CPU == 1'b0));
  assign TCD_bar = !((Q == 4'h0) && (CPD == 1'b0));

  int n_cpu = 0;
  int n_cpd = 0;
  int cyc   = 0;
  always @(posedge CPU) n_cpu <= n_cpu + 1;
  always @(posedge CPD) n_cpd <= n_cpd + 1;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         lat;
    bit         carry;
    bit         borrow;
    logic [3:0] q;
    int         ncpu;
    int         ncpd;
    int         acc;
    int         cpu_base;
    int         cpd_base;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_d = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every DONE and checks strobe shape
  logic       pl_prev = 1'b1;
  logic [3:0] d_prev = 4'd0;
  int         pl_low = 0;
  bit         both_low = 1'b0;
  exp_t       e;
  always @(negedge clk) begin
    if (RST_bar) begin
      if (!CPU && !CPD) both_low <= 1'b1;
      if (!PL_bar && pl_prev) chk("d_setup", d_prev, exp_d);
      if (!PL_bar) pl_low <= pl_low + 1;
      else if (!pl_prev) begin
        chk("pl_width", pl_low, 2);
        pl_low <= 0;
      end
      if (DONE) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc - e.acc, e.lat);
          chk("carry", CARRY, e.carry);
          chk("borrow", BORROW, e.borrow);
          chk("q", Q, e.q);
          chk("cpu_edges", n_cpu - e.cpu_base, e.ncpu);
          chk("cpd_edges", n_cpd - e.cpd_base, e.ncpd);
        end
      end
    end
    pl_prev <= PL_bar;
    d_prev  <= D;
  end

  task automatic issue(input logic [1:0] op, input int cnt, input logic [3:0] data,
                       input bit want, input int lat, input bit c, input bit b,
                       input logic [3:0] q, input int ncpu, input int ncpd);
    int guard = 0;
    @(negedge clk);
    while (!CMD_READY && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!CMD_READY) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_COUNT = 8'(cnt);
    CMD_DATA  = data;
    if (op == OP_LOAD) exp_d = data;
    if (want) sb.push_back('{lat, c, b, q, ncpu, ncpd, cyc, n_cpu, n_cpd});
    @(negedge clk);
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_mr", MR, 1);
    chk("rst_pl", PL_bar, 1);
    chk("rst_cpu", CPU, 1);
    chk("rst_cpd", CPD, 1);
    chk("rst_d", D, 0);
    chk("rst_ready", CMD_READY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_flags", {CARRY, BORROW}, 0);
    @(posedge clk);
    #1 RST_bar = 1'b1;
    @(negedge clk);
    chk("hold_mr", MR, 1);
    chk("hold_ready", CMD_READY, 0);
    @(negedge clk);
    chk("idle_mr", MR, 0);
    chk("idle_ready", CMD_READY, 1);
    chk("idle_q", Q, 0);

    issue(OP_LOAD, 0, 4'hA, 1, 6, 0, 0, 4'hA, 0, 0);   wait_done();
    issue(OP_LOAD, 0, 4'hD, 1, 6, 0, 0, 4'hD, 0, 0);   wait_done();
    issue(OP_UP,   5, 4'h0, 1, 21, 1, 0, 4'h2, 5, 0);  wait_done();
    chk("carry_sticky", CARRY, 1);
    issue(OP_UP,   0, 4'h0, 1, 1, 0, 0, 4'h2, 0, 0);   wait_done();
    issue(OP_CLEAR, 0, 4'h0, 1, 5, 0, 0, 4'h0, 0, 0);  wait_done();
    issue(OP_DOWN, 1, 4'h0, 1, 5, 0, 1, 4'hF, 0, 1);   wait_done();
    issue(OP_DOWN, 3, 4'h0, 1, 13, 0, 0, 4'hC, 0, 3);  wait_done();

    // Abort a 10-step up half way through
    issue(OP_UP, 10, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0);
    repeat (15) @(negedge clk);
    #3 RST_bar = 1'b0;
    #1;
    chk("abort_mr", MR, 1);
    chk("abort_cpu", CPU, 1);
    chk("abort_cpd", CPD, 1);
    chk("abort_ready", CMD_READY, 0);
    chk("abort_done", DONE, 0);
    chk("abort_q", Q, 0);
    repeat (2) @(posedge clk);
    #1 RST_bar = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_abort_q", Q, 0);
    chk("post_abort_ready", CMD_READY, 1);
    issue(OP_LOAD, 0, 4'h5, 1, 6, 0, 0, 4'h5, 0, 0);   wait_done();

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("cpu_cpd_both_low", both_low, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
